// File: rtl/lsseq_pkg.sv
// Shared encodings for the load/store sequencer: opcodes, FSM states and
// the DataSrc writeback mux select values.
package lsseq_pkg;

    typedef enum logic [2:0] {
        OP_LW = 3'b000,
        OP_LH = 3'b001,
        OP_LB = 3'b010,
        OP_SW = 3'b100,
        OP_SH = 3'b101,
        OP_SB = 3'b110
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WB    = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam logic SRC_TEMP = 1'b0;
    localparam logic SRC_SIZE = 1'b1;

    // Loads write the register file; everything else does not.
    function automatic logic is_load(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
    endfunction

    // Sub-word stores read the old word first so it can be merged.
    function automatic logic needs_read(input logic [2:0] op);
        return is_load(op) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/load_store_seq_size_extract.sv
// Sub-word handling: extends LH/LB load values and merges SH/SB store data
// into the previously read word.
// Build option: define LSSEQ_SIGNED_LOAD_EN to sign-extend LH/LB loads.
module size_extract
    import lsseq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] store_i,
    output logic [DATA_W-1:0] size_o,
    output logic [DATA_W-1:0] merge_o
);

    logic ext_h;
    logic ext_b;

`ifdef LSSEQ_SIGNED_LOAD_EN
    assign ext_h = word_i[15];
    assign ext_b = word_i[7];
`else
    assign ext_h = 1'b0;
    assign ext_b = 1'b0;
`endif

    // Pick the extended load value and the merged store word by opcode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        size_o  = word_i;
        merge_o = store_i;
        case (op_i)
            OP_LH:   size_o  = {{(DATA_W-16){ext_h}}, word_i[15:0]};
            OP_LB:   size_o  = {{(DATA_W-8){ext_b}}, word_i[7:0]};
            OP_SH:   merge_o = {word_i[DATA_W-1:16], store_i[15:0]};
            OP_SB:   merge_o = {word_i[DATA_W-1:8], store_i[7:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_seq.sv
// Multicycle load/store sequencer: runs the memory read/write phases, holds
// the word temp register and the size-handled load value, and drives the
// DataSrc writeback select. All outputs are registered with the state.
// Build option: LSSEQ_SIGNED_LOAD_EN (sign-extending LH/LB, see size_extract).
module load_store_seq
    import lsseq_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] temp_q,
    output logic [DATA_W-1:0] size_q,
    output logic              data_src_sel,
    output logic              reg_wr,
    output logic              busy,
    output logic              done
);

    state_e            state_q;
    logic [2:0]        op_q;
    logic [DATA_W-1:0] store_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] ext_size;
    logic [DATA_W-1:0] ext_merge;

    // Extraction works on the word arriving from memory so size_q and the
    // merged store word are ready in the cycle right after READ.
    size_extract #(
        .DATA_W (DATA_W)
    ) u_size_extract (
        .op_i    (op_q),
        .word_i  (mem_rdata),
        .store_i (store_q),
        .size_o  (ext_size),
        .merge_o (ext_merge)
    );

    // Sequencer FSM; outputs are set on entry to each state so they are Moore and glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            op_q         <= 3'b000;
            store_q      <= '0;
            cnt_q        <= 3'd0;
            temp_q       <= '0;
            size_q       <= '0;
            mem_addr     <= '0;
            mem_wr       <= 1'b0;
            mem_wdata    <= '0;
            data_src_sel <= SRC_TEMP;
            reg_wr       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        store_q <= store_data;
                        cnt_q   <= 3'd0;
                        busy    <= 1'b1;
                        if (needs_read(op)) begin
                            state_q  <= READ;
                            mem_addr <= addr;
                        end else if (op == OP_SW) begin
                            state_q   <= WRITE;
                            mem_addr  <= addr;
                            mem_wr    <= 1'b1;
                            mem_wdata <= store_data;
                            done      <= 1'b1;
                        end else begin
                            state_q <= FIN;
                            done    <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == 3'(MEM_LAT)) begin
                        temp_q <= mem_rdata;
                        size_q <= ext_size;
                        done   <= 1'b1;
                        if (is_load(op_q)) begin
                            state_q      <= WB;
                            reg_wr       <= 1'b1;
                            data_src_sel <= (op_q == OP_LW) ? SRC_TEMP : SRC_SIZE;
                        end else begin
                            state_q   <= WRITE;
                            mem_wr    <= 1'b1;
                            mem_wdata <= ext_merge;
                        end
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    // WB, WRITE and FIN all last one cycle and return to IDLE.
                    state_q      <= IDLE;
                    mem_addr     <= '0;
                    mem_wr       <= 1'b0;
                    mem_wdata    <= '0;
                    data_src_sel <= SRC_TEMP;
                    reg_wr       <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_seq.sv
// Self-checking bench for load_store_seq: a vector table of transactions
// with a scoreboard queue, plus hand-written reset and busy-start sequences.
module tb_load_store_seq;
    import lsseq_pkg::*;

    localparam int unsigned MEM_LAT = 1;
    localparam int unsigned DATA_W  = 32;
    localparam int          LD_LAT  = 2 + MEM_LAT;
`ifdef LSSEQ_SIGNED_LOAD_EN
    localparam bit SIGNED_LD = 1'b1;
`else
    localparam bit SIGNED_LD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [2:0]        op;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] temp_q;
    logic [DATA_W-1:0] size_q;
    logic              data_src_sel;
    logic              reg_wr;
    logic              busy;
    logic              done;

    load_store_seq #(
        .MEM_LAT (MEM_LAT),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .op           (op),
        .addr         (addr),
        .store_data   (store_data),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .temp_q       (temp_q),
        .size_q       (size_q),
        .data_src_sel (data_src_sel),
        .reg_wr       (reg_wr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        int          lat;
        logic        reg_wr;
        int          wr_pulses;
        logic        src;
        logic        chk_temp;
        logic [31:0] temp;
        logic        chk_size;
        logic [31:0] size;
        logic [31:0] wdata;
        bit          poke;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a, input logic [31:0] s,
                                input logic [31:0] rd, input int lat, input logic rw, input int wp,
                                input logic src, input logic ct, input logic [31:0] t,
                                input logic cs, input logic [31:0] sz, input logic [31:0] wd,
                                input bit pk);
        vec_t v;
        v.op = o; v.addr = a; v.store = s; v.rdata = rd; v.lat = lat; v.reg_wr = rw;
        v.wr_pulses = wp; v.src = src; v.chk_temp = ct; v.temp = t; v.chk_size = cs;
        v.size = sz; v.wdata = wd; v.poke = pk;
        return v;
    endfunction

    // Drive one transaction, watch it until done, then score it.
    task automatic run_txn(input int idx, input vec_t v);
        int   cyc;
        int   pulses;
        int   overlap;
        vec_t e;
        addr       = v.addr;
        store_data = v.store;
        mem_rdata  = v.rdata;
        op         = v.op;
        start      = 1'b1;
        sb.push_back(v);
        step();
        start   = 1'b0;
        cyc     = 1;
        pulses  = 0;
        overlap = 0;
        check($sformatf("v%0d_busy_c1", idx), 32'(busy), 32'd1);
        if (needs_read(v.op)) check($sformatf("v%0d_read_addr", idx), mem_addr, v.addr);
        for (int k = 0; k < 16; k++) begin
            if (mem_wr) pulses++;
            if (mem_wr && reg_wr) overlap++;
            if (done) break;
            if (v.poke) begin
                start      = 1'b1;
                op         = OP_SW;
                store_data = 32'hFFFF_FFFF;
                addr       = 32'hFFFF_FFF0;
            end
            step();
            cyc++;
        end
        if (v.poke) begin
            start = 1'b1;
            op    = OP_SW;
        end
        check($sformatf("v%0d_done_seen", idx), 32'(done), 32'd1);
        if (done) begin
            check($sformatf("v%0d_sb_nonempty", idx), 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(e.lat));
                check($sformatf("v%0d_reg_wr", idx), 32'(reg_wr), 32'(e.reg_wr));
                check($sformatf("v%0d_mem_wr_pulses", idx), 32'(pulses), 32'(e.wr_pulses));
                check($sformatf("v%0d_no_overlap", idx), 32'(overlap), 32'd0);
                if (e.reg_wr) check($sformatf("v%0d_data_src_sel", idx), 32'(data_src_sel), 32'(e.src));
                if (e.chk_temp) check($sformatf("v%0d_temp_q", idx), temp_q, e.temp);
                if (e.chk_size) check($sformatf("v%0d_size_q", idx), size_q, e.size);
                if (e.wr_pulses != 0) begin
                    check($sformatf("v%0d_mem_wdata", idx), mem_wdata, e.wdata);
                    check($sformatf("v%0d_write_addr", idx), mem_addr, e.addr);
                end
            end
        end
        step();
        check($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
        check($sformatf("v%0d_idle_busy", idx), 32'(busy), 32'd0);
        start = 1'b0;
        step();
        check($sformatf("v%0d_no_queued_start", idx), 32'(busy | done | mem_wr), 32'd0);
    endtask

    initial begin
        vecs[0] = mk(OP_LW, 32'h40, 32'h0, 32'hDEAD_BEEF, LD_LAT, 1, 0, SRC_TEMP,
                     1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'h0, 0);
        vecs[1] = mk(OP_LB, 32'h44, 32'h0, 32'h1234_56F0, LD_LAT, 1, 0, SRC_SIZE,
                     1, 32'h1234_56F0, 1, SIGNED_LD ? 32'hFFFF_FFF0 : 32'h0000_00F0, 32'h0, 0);
        vecs[2] = mk(OP_LH, 32'h48, 32'h0, 32'h0000_8001, LD_LAT, 1, 0, SRC_SIZE,
                     1, 32'h0000_8001, 1, SIGNED_LD ? 32'hFFFF_8001 : 32'h0000_8001, 32'h0, 0);
        vecs[3] = mk(OP_LB, 32'h4C, 32'h0, 32'hFFFF_FF7F, LD_LAT, 1, 0, SRC_SIZE,
                     1, 32'hFFFF_FF7F, 1, 32'h0000_007F, 32'h0, 0);
        vecs[4] = mk(OP_SB, 32'h80, 32'h0000_0011, 32'hAABB_CCDD, LD_LAT, 0, 1, SRC_TEMP,
                     1, 32'hAABB_CCDD, 0, 32'h0, 32'hAABB_CC11, 1);
        vecs[5] = mk(OP_SH, 32'h84, 32'h0000_0011, 32'hAABB_CCDD, LD_LAT, 0, 1, SRC_TEMP,
                     1, 32'hAABB_CCDD, 0, 32'h0, 32'hAABB_0011, 0);
        vecs[6] = mk(OP_SW, 32'h88, 32'hCAFE_F00D, 32'h1111_1111, 1, 0, 1, SRC_TEMP,
                     0, 32'h0, 0, 32'h0, 32'hCAFE_F00D, 0);
        vecs[7] = mk(OP_LH, 32'h8C, 32'h0, 32'h1234_ABCD, LD_LAT, 1, 0, SRC_SIZE,
                     1, 32'h1234_ABCD, 1, SIGNED_LD ? 32'hFFFF_ABCD : 32'h0000_ABCD, 32'h0, 1);
        vecs[8] = mk(3'b111, 32'h90, 32'h0, 32'h5555_5555, 1, 0, 0, SRC_TEMP,
                     0, 32'h0, 0, 32'h0, 32'h0, 1);
        vecs[9] = mk(3'b011, 32'h94, 32'h0, 32'h5555_5555, 1, 0, 0, SRC_TEMP,
                     0, 32'h0, 0, 32'h0, 32'h0, 0);

        reset_n    = 1'b0;
        start      = 1'b0;
        op         = 3'b000;
        addr       = '0;
        store_data = '0;
        mem_rdata  = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_src", 32'(data_src_sel), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_temp_q", temp_q, 32'h0);
        check("rst_size_q", size_q, 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // Reset in the middle of a READ aborts to IDLE at once.
        addr      = 32'h100;
        op        = OP_LW;
        mem_rdata = 32'h0BAD_F00D;
        start     = 1'b1;
        step();
        start = 1'b0;
        check("midread_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midread_busy", 32'(busy), 32'd0);
        check("midread_mem_addr", mem_addr, 32'h0);
        check("midread_temp_q", temp_q, 32'h0);
        check("midread_size_q", size_q, 32'h0);
        check("midread_flags", 32'({done, reg_wr, mem_wr, data_src_sel}), 32'd0);
        #3;
        reset_n = 1'b1;
        step();
        check("midread_idle_after", 32'(busy), 32'd0);
        run_txn(10, vecs[0]);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
